// File: rtl/ringosc_pkg.sv
// rtl/ringosc_pkg.sv - shared types and default sizing for the ring-oscillator frequency meter
package ringosc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GATE   = 2'd2,
        DONE   = 2'd3
    } freq_state_t;

    localparam int DEF_COUNT_W       = 16;
    localparam int DEF_GATE_W        = 16;
    localparam int DEF_SETTLE_CYCLES = 8;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - 2-FF synchronizer with registered rising-edge pulse
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_pulse
);

    (* keep = "true" *) logic r_meta;
    (* keep = "true" *) logic r_sync;
    logic r_prev;
    logic r_pulse;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_meta  <= i_async;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_pulse <= r_sync & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/ringosc_freq_meter.sv
// rtl/ringosc_freq_meter.sv - gated edge counter that measures the ring-oscillator output
module ringosc_freq_meter
    import ringosc_pkg::*;
#(
    parameter int COUNT_W       = DEF_COUNT_W,
    parameter int GATE_W        = DEF_GATE_W,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               osc_in,
    input  logic               start,
    input  logic [GATE_W-1:0]  gate_len,
    output logic               osc_en,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] count,
    output logic               overflow
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic w_edge;

    sync_edge_det u_sync_edge_det (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (osc_in),
        .o_pulse (w_edge)
    );

    freq_state_t        r_state;
    logic [SET_W-1:0]   r_settle_cnt;
    logic [GATE_W-1:0]  r_gate_last;
    logic [GATE_W-1:0]  r_gate_cnt;
    logic [COUNT_W-1:0] r_edge_cnt;
    logic               r_ovf;
    logic [COUNT_W-1:0] r_count;
    logic               r_overflow;
    logic               r_osc_en;
    logic               r_busy;
    logic               r_done;

    logic               w_cnt_max;
    logic [COUNT_W-1:0] w_edge_cnt_nxt;
    logic               w_ovf_nxt;

    // An edge arriving while already at all-ones is dropped and flagged instead of wrapping.
    always_comb begin
        w_cnt_max      = &r_edge_cnt;
        w_edge_cnt_nxt = r_edge_cnt;
        w_ovf_nxt      = r_ovf;
        if (w_edge) begin
            if (w_cnt_max) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_edge_cnt_nxt = r_edge_cnt + COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_settle_cnt <= '0;
            r_gate_last  <= '0;
            r_gate_cnt   <= '0;
            r_edge_cnt   <= '0;
            r_ovf        <= 1'b0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_osc_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        // Counters run down to zero, so hold length-1; a zero length means one cycle.
                        r_gate_last  <= (gate_len == '0) ? '0 : gate_len - GATE_W'(1);
                        r_settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
                        r_osc_en     <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (r_settle_cnt == '0) begin
                        r_edge_cnt <= '0;
                        r_ovf      <= 1'b0;
                        r_gate_cnt <= r_gate_last;
                        r_state    <= GATE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - SET_W'(1);
                    end
                end
                GATE: begin
                    r_edge_cnt <= w_edge_cnt_nxt;
                    r_ovf      <= w_ovf_nxt;
                    if (r_gate_cnt == '0) begin
                        r_count    <= w_edge_cnt_nxt;
                        r_overflow <= w_ovf_nxt;
                        r_done     <= 1'b1;
                        r_osc_en   <= 1'b0;
                        r_state    <= DONE;
                    end else begin
                        r_gate_cnt <= r_gate_cnt - GATE_W'(1);
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_osc_en <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign osc_en   = r_osc_en;
    assign busy     = r_busy;
    assign done     = r_done;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_ringosc_freq_meter.sv
// tb/tb_ringosc_freq_meter.sv - self-checking bench for ringosc_freq_meter
module tb_ringosc_freq_meter;

    localparam int S = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        osc_in = 1'b0;
    logic        start = 1'b0;
    logic [15:0] gate_len = '0;
    logic        osc_en, busy, done, overflow;
    logic [15:0] count;

    logic        start4 = 1'b0;
    logic [15:0] gate4 = '0;
    logic        osc_en4, busy4, done4, overflow4;
    logic [3:0]  count4;

    ringosc_freq_meter dut (
        .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .start(start), .gate_len(gate_len),
        .osc_en(osc_en), .busy(busy), .done(done), .count(count), .overflow(overflow)
    );

    ringosc_freq_meter #(.COUNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .start(start4), .gate_len(gate4),
        .osc_en(osc_en4), .busy(busy4), .done(done4), .count(count4), .overflow(overflow4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Oscillator model: square wave of period osc_div clk cycles, 0 means stuck low.
    int osc_div = 4;
    int ph = 0;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (osc_div == 0) begin
                osc_in = 1'b0;
                ph = 0;
            end else begin
                ph++;
                if (ph >= osc_div / 2) begin
                    osc_in = ~osc_in;
                    ph = 0;
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    typedef struct {
        int          at;
        logic [15:0] cnt;
        logic        ovf;
    } exp_t;
    exp_t exp_q[$];

    logic busy_chk = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (busy_chk) begin
            check("busy_after_done", busy, 0);
            busy_chk = 1'b0;
        end
        if (done) begin
            done_seen++;
            busy_chk = 1'b1;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("done_cycle", cyc, e.at);
                check("count", count, e.cnt);
                check("overflow", overflow, e.ovf);
                check("osc_en_in_done", osc_en, 0);
            end
        end
    end

    task automatic launch(input logic [15:0] g, input logic [15:0] ec, input logic eo);
        int L;
        L = (g == 0) ? 1 : int'(g);
        @(negedge clk);
        gate_len = g;
        start = 1'b1;
        exp_q.push_back('{cyc + 1 + S + L, ec, eo});
        @(negedge clk);
        start = 1'b0;
        gate_len = 16'hffff;
    endtask

    task automatic wait_q(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("done_timeout", 1, 0);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run4(input logic [15:0] g, input logic [3:0] ec, input logic eo);
        int at;
        int n;
        @(negedge clk);
        gate4 = g;
        start4 = 1'b1;
        at = cyc + 1 + S + int'(g);
        @(negedge clk);
        start4 = 1'b0;
        gate4 = '0;
        n = 0;
        while (!done4 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!done4) begin
            check("done4_timeout", 1, 0);
        end else begin
            check("done4_cycle", cyc, at);
            check("count4", count4, ec);
            check("overflow4", overflow4, eo);
            check("osc_en4_in_done", osc_en4, 0);
            @(negedge clk);
            check("busy4_after_done", busy4, 0);
        end
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] gate;
        int          div;
        logic [15:0] exp_cnt;
        logic        exp_ovf;
    } vec_t;
    vec_t vecs[7];

    initial begin
        int d0;
        int n;
        vecs[0] = '{16'd64,  8,  16'd8,  1'b0};
        vecs[1] = '{16'd100, 0,  16'd0,  1'b0};
        vecs[2] = '{16'd32,  4,  16'd8,  1'b0};
        vecs[3] = '{16'd0,   0,  16'd0,  1'b0};
        vecs[4] = '{16'd1,   0,  16'd0,  1'b0};
        vecs[5] = '{16'd48,  16, 16'd3,  1'b0};
        vecs[6] = '{16'd256, 8,  16'd32, 1'b0};

        // Reset with the oscillator toggling.
        rst_n = 1'b0;
        osc_div = 4;
        repeat (3) begin
            @(negedge clk);
            check("reset_osc_en", osc_en, 0);
        end
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_count", count, 0);
        check("reset_overflow", overflow, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            osc_div = vecs[i].div;
            repeat (4) @(negedge clk);
            launch(vecs[i].gate, vecs[i].exp_cnt, vecs[i].exp_ovf);
            check("busy_in_run", busy, 1);
            check("osc_en_in_run", osc_en, 1);
            wait_q(400);
        end

        // Result is held through idle time.
        osc_div = 8;
        repeat (4) @(negedge clk);
        launch(16'd64, 16'd8, 1'b0);
        wait_q(200);
        repeat (30) @(negedge clk);
        check("hold_count", count, 8);
        check("idle_osc_en", osc_en, 0);
        osc_div = 0;
        repeat (4) @(negedge clk);
        launch(16'd100, 16'd0, 1'b0);
        wait_q(200);
        repeat (30) @(negedge clk);
        check("hold_count_dead", count, 0);

        // Saturation on the narrow counter, then recovery.
        osc_div = 4;
        repeat (4) @(negedge clk);
        run4(16'd100, 4'd15, 1'b1);
        osc_div = 8;
        repeat (4) @(negedge clk);
        run4(16'd32, 4'd4, 1'b0);

        // start pulses during SETTLE and GATE are ignored.
        d0 = done_seen;
        launch(16'd64, 16'd8, 1'b0);
        repeat (2) @(negedge clk);
        start = 1'b1; gate_len = 16'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_q(200);
        repeat (20) @(negedge clk);
        check("single_done", done_seen - d0, 1);

        // start held high: back-to-back with one IDLE cycle between.
        @(negedge clk);
        gate_len = 16'd16;
        start = 1'b1;
        exp_q.push_back('{cyc + 1 + S + 16, 16'd2, 1'b0});
        exp_q.push_back('{cyc + 1 + S + 16 + 2 + S + 16, 16'd2, 1'b0});
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_q(100);

        // Abort mid-GATE with a one-cycle reset.
        @(negedge clk);
        gate_len = 16'd64;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (S + 20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_osc_en", osc_en, 0);
        check("abort_busy", busy, 0);
        check("abort_count", count, 0);
        d0 = done_seen;
        repeat (90) @(negedge clk);
        check("abort_no_done", done_seen - d0, 0);
        launch(16'd64, 16'd8, 1'b0);
        wait_q(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
